// File: rtl/eth_helper_pkg.sv
// Shared constants and state encoding for the Ethernet stream helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_helper_pkg;

  // Type tag carried in the top bits of metadata and strobe beats
  localparam int              STREAM_TYPE_FIELD_W = 3;
  localparam logic [2:0]      STREAM_TYPE_W       = 3'b011;

  // Receive-side W-burst rebuilder states
  typedef enum logic [1:0] {
    S2AW_IDLE    = 2'd0,
    S2AW_COLLECT = 2'd1,
    S2AW_REPLAY  = 2'd2,
    S2AW_DROP    = 2'd3
  } s2aw_state_e;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_to_axi_w_if.sv
// Stream ingress plus AXI W egress bundle for stream_to_axi_w.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready on the stream side, AXIM_wvalid/AXIM_wready on AXI.
interface stream_to_axi_w_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;
  logic [DATA_WIDTH-1:0]   s_data;

  logic [ID_WIDTH-1:0]     AXIM_wid;
  logic [DATA_WIDTH-1:0]   AXIM_wdata;
  logic [DATA_WIDTH/8-1:0] AXIM_wstrb;
  logic                    AXIM_wlast;
  logic [USER_WIDTH-1:0]   AXIM_wuser;
  logic                    AXIM_wvalid;
  logic                    AXIM_wready;

  // Block view: consumes the stream, masters the AXI W channel
  modport master (
    input  s_valid, s_last, s_data, AXIM_wready,
    output s_ready, AXIM_wid, AXIM_wdata, AXIM_wstrb, AXIM_wlast, AXIM_wuser, AXIM_wvalid
  );

  // Environment view: stream source and AXI W slave
  modport slave (
    output s_valid, s_last, s_data, AXIM_wready,
    input  s_ready, AXIM_wid, AXIM_wdata, AXIM_wstrb, AXIM_wlast, AXIM_wuser, AXIM_wvalid
  );
endinterface

// File: rtl/stream_to_axi_w_buf.sv
// Data-beat holding buffer: register array, one write port, combinational read.
// Latency: write visible the cycle after i_wr_en; read is same-cycle.
// Backpressure: none, the caller sequences writes and reads.
module stream_to_axi_w_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Capture one data beat per write strobe; cleared on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_to_axi_w.sv
// Rebuilds one AXI W burst from a framed stream packet (metadata, data beats, strobe beat).
// Latency: first W beat the cycle after the strobe beat, then one beat per cycle.
// Backpressure: s_ready held low during replay; W beat held stable while AXIM_wready is low.
module stream_to_axi_w
  import eth_helper_pkg::*;
#(
  parameter int                             DATA_WIDTH        = 128,
  parameter int                             ID_WIDTH          = 32,
  parameter int                             USER_WIDTH        = 64,
  parameter int                             STREAM_TYPE_WIDTH = STREAM_TYPE_FIELD_W,
  parameter logic [STREAM_TYPE_WIDTH-1:0]   STREAM_TYPE       = STREAM_TYPE_W,
  parameter int                             BURST_SIZE        = 4
) (
  input  logic               clk,
  input  logic               resetn,
  stream_to_axi_w_if.master  bus,
  output logic               err
);

  localparam int S     = DATA_WIDTH / 8;
  localparam int SW    = BURST_SIZE * S;
  localparam int CNT_W = $clog2(BURST_SIZE + 1);
  localparam int RD_W  = clog2_min1(BURST_SIZE);

  s2aw_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic [RD_W-1:0]       r_rd, w_rd_nxt;
  logic [ID_WIDTH-1:0]   r_id, w_id_nxt;
  logic [SW-1:0]         r_strb, w_strb_nxt;
  logic                  r_err, w_err_nxt;

  logic                  w_buf_we;
  logic [DATA_WIDTH-1:0] w_buf_rdat;
  logic                  w_tag_ok;
  logic [CNT_W-1:0]      w_last_idx;
  logic [CNT_W-1:0]      w_sel;
  logic                  w_is_last;
  logic [S-1:0]          w_strb_beat;

  logic                  w_s_ready;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [S-1:0]          w_wstrb;

  stream_to_axi_w_buf #(
    .DEPTH (BURST_SIZE),
    .WIDTH (DATA_WIDTH),
    .AW    (RD_W)
  ) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (w_buf_we),
    .i_wr_addr (r_count[RD_W-1:0]),
    .i_wr_dat  (bus.s_data),
    .i_rd_addr (r_rd),
    .o_rd_dat  (w_buf_rdat)
  );

  assign w_tag_ok   = (bus.s_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] == STREAM_TYPE);
  assign w_last_idx = r_count - CNT_W'(1);
  assign w_is_last  = (CNT_W'(r_rd) == w_last_idx);
  // Latest data beat sits in the strobe LSBs, so beat rd maps to slot count-1-rd
  assign w_sel       = w_last_idx - CNT_W'(r_rd);
  assign w_strb_beat = r_strb[int'(w_sel[RD_W-1:0]) * S +: S];

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd;
    w_id_nxt    = r_id;
    w_strb_nxt  = r_strb;
    w_err_nxt   = 1'b0;
    w_buf_we    = 1'b0;
    w_s_ready   = 1'b0;
    w_wvalid    = 1'b0;
    w_wlast     = 1'b0;
    w_wdata     = '0;
    w_wstrb     = '0;

    case (r_state)
      S2AW_IDLE: begin
        w_s_ready = 1'b1;
        if (bus.s_valid) begin
          if (w_tag_ok && !bus.s_last) begin
            w_id_nxt    = bus.s_data[ID_WIDTH-1:0];
            w_count_nxt = '0;
            w_state_nxt = S2AW_COLLECT;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = bus.s_last ? S2AW_IDLE : S2AW_DROP;
          end
        end
      end

      S2AW_COLLECT: begin
        w_s_ready = 1'b1;
        if (bus.s_valid) begin
          if (!bus.s_last) begin
            if (r_count < CNT_W'(BURST_SIZE)) begin
              w_buf_we    = 1'b1;
              w_count_nxt = r_count + CNT_W'(1);
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S2AW_DROP;
            end
          end else if (w_tag_ok && (r_count != '0)) begin
            w_strb_nxt  = bus.s_data[SW-1:0];
            w_rd_nxt    = '0;
            w_state_nxt = S2AW_REPLAY;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S2AW_IDLE;
          end
        end
      end

      S2AW_REPLAY: begin
        w_wvalid = 1'b1;
        w_wdata  = w_buf_rdat;
        w_wstrb  = w_strb_beat;
        w_wlast  = w_is_last;
        if (bus.AXIM_wready) begin
          if (w_is_last) w_state_nxt = S2AW_IDLE;
          else           w_rd_nxt    = r_rd + RD_W'(1);
        end
      end

      S2AW_DROP: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && bus.s_last) w_state_nxt = S2AW_IDLE;
      end

      default: w_state_nxt = S2AW_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S2AW_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Packet context registers: beat count, replay pointer, ID, strobes, error pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_rd    <= '0;
      r_id    <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_rd    <= w_rd_nxt;
      r_id    <= w_id_nxt;
      r_strb  <= w_strb_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.AXIM_wvalid = w_wvalid;
  assign bus.AXIM_wlast  = w_wlast;
  assign bus.AXIM_wdata  = w_wdata;
  assign bus.AXIM_wstrb  = w_wstrb;
  assign bus.AXIM_wid    = r_id;
  assign bus.AXIM_wuser  = '0;
  assign err             = r_err;

endmodule

// File: tb/tb_stream_to_axi_w.sv
// Directed bench for stream_to_axi_w: packet table plus stall and reset sequences.
// Latency: checks first W beat one cycle after the strobe beat.
// Backpressure: exercises AXIM_wready stalls and s_ready deassertion during replay.
module tb_stream_to_axi_w;

  localparam int DW = 128;
  localparam int NV = 8;

  typedef struct {
    logic [2:0]       meta_tag;
    logic [2:0]       strb_tag;
    logic [31:0]      id;
    int               ndata;
    logic [63:0]      strobes;
    int               err_beat;  // beat index that must raise err, -1 for none
    int               exp_nw;    // W beats expected
    logic [3:0][15:0] exp_strb;  // hand-computed per-beat strobes, [0] = first beat
  } vec_t;

  logic clk;
  logic resetn;
  logic err;
  int   tests;
  int   fails;
  vec_t vecs [NV];

  stream_to_axi_w_if #(.DATA_WIDTH(128), .ID_WIDTH(32), .USER_WIDTH(64)) bus ();

  stream_to_axi_w #(
    .DATA_WIDTH (128),
    .ID_WIDTH   (32),
    .USER_WIDTH (64),
    .BURST_SIZE (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk_data(input int v, input int k);
    return {4{8'(v), 8'(k), 16'hC0DE}};
  endfunction

  function automatic vec_t mk_vec(input logic [2:0] mt, input logic [2:0] st, input logic [31:0] id,
                                  input int nd, input logic [63:0] sb, input int eb, input int nw,
                                  input logic [63:0] es);
    vec_t v;
    v.meta_tag = mt; v.strb_tag = st; v.id = id; v.ndata = nd; v.strobes = sb;
    v.err_beat = eb; v.exp_nw = nw; v.exp_strb = es;
    return v;
  endfunction

  // Drive metadata, data and strobe beats; checks s_ready, err timing and no early wvalid
  task automatic send_pkt(input vec_t v, input int vi);
    int nb;
    logic [127:0] d;
    logic l;
    nb = v.ndata + 2;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (b > 0) chk("err_beat", 128'(err), 128'(b - 1 == v.err_beat));
      chk("wvalid_in", 128'(bus.AXIM_wvalid), 128'(0));
      if (b == 0) begin
        d = {v.meta_tag, 93'b0, v.id}; l = 1'b0;
      end else if (b == nb - 1) begin
        d = {v.strb_tag, 61'b0, v.strobes}; l = 1'b1;
      end else begin
        d = mk_data(vi, b - 1); l = 1'b0;
      end
      bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
      chk("s_ready_in", 128'(bus.s_ready), 128'(1));
    end
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    chk("err_last", 128'(err), 128'(nb - 1 == v.err_beat));
  endtask

  task automatic chk_beat(input vec_t v, input int vi, input int k);
    chk("wvalid", 128'(bus.AXIM_wvalid), 128'(1));
    chk("wdata",  bus.AXIM_wdata, mk_data(vi, k));
    chk("wstrb",  128'(bus.AXIM_wstrb), 128'(v.exp_strb[k]));
    chk("wlast",  128'(bus.AXIM_wlast), 128'(k == v.exp_nw - 1));
    chk("wid",    128'(bus.AXIM_wid), 128'(v.id));
    chk("s_ready_replay", 128'(bus.s_ready), 128'(0));
  endtask

  // Accept the replayed burst, optionally stalling one beat for several cycles
  task automatic collect_w(input vec_t v, input int vi, input int stall_beat, input int stall_cyc);
    for (int k = 0; k < v.exp_nw; k++) begin
      if (k == stall_beat) begin
        for (int c = 0; c < stall_cyc; c++) begin
          bus.AXIM_wready = 1'b0;
          chk_beat(v, vi, k);
          @(negedge clk);
        end
      end
      bus.AXIM_wready = 1'b1;
      chk_beat(v, vi, k);
      @(negedge clk);
    end
    bus.AXIM_wready = 1'b0;
    if (v.exp_nw == 0) @(negedge clk);
    chk("wvalid_after", 128'(bus.AXIM_wvalid), 128'(0));
    chk("wlast_after",  128'(bus.AXIM_wlast), 128'(0));
    chk("wdata_after",  bus.AXIM_wdata, 128'(0));
    chk("s_ready_after", 128'(bus.s_ready), 128'(1));
    chk("err_after",    128'(err), 128'(0));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.AXIM_wready = 1'b0;

    vecs[0] = mk_vec(3'b011, 3'b011, 32'h5, 4, 64'hFFFF_0F0F_00FF_FFFF, -1, 4,
                     {16'hFFFF, 16'h00FF, 16'h0F0F, 16'hFFFF});
    vecs[1] = mk_vec(3'b011, 3'b011, 32'hDEAD_BEEF, 1, 64'h3, -1, 1,
                     {16'h0, 16'h0, 16'h0, 16'h0003});
    vecs[2] = mk_vec(3'b011, 3'b011, 32'h0000_0A5A, 3, 64'h0000_1111_2222_3333, -1, 3,
                     {16'h0, 16'h3333, 16'h2222, 16'h1111});
    vecs[3] = mk_vec(3'b001, 3'b011, 32'h7, 2, 64'hFFFF, 0, 0, 64'h0);
    vecs[4] = mk_vec(3'b011, 3'b011, 32'h9, 5, 64'hFFFF_FFFF_FFFF_FFFF, 5, 0, 64'h0);
    vecs[5] = mk_vec(3'b011, 3'b011, 32'h1, 0, 64'h1, 1, 0, 64'h0);
    vecs[6] = mk_vec(3'b011, 3'b111, 32'h2, 2, 64'hFF, 3, 0, 64'h0);
    vecs[7] = mk_vec(3'b011, 3'b011, 32'h1234_5678, 4, 64'h8000_4000_2000_1000, -1, 4,
                     {16'h1000, 16'h2000, 16'h4000, 16'h8000});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wvalid", 128'(bus.AXIM_wvalid), 128'(0));
    chk("rst_wlast",  128'(bus.AXIM_wlast), 128'(0));
    chk("rst_wid",    128'(bus.AXIM_wid), 128'(0));
    chk("rst_wdata",  bus.AXIM_wdata, 128'(0));
    chk("rst_wstrb",  128'(bus.AXIM_wstrb), 128'(0));
    chk("rst_err",    128'(err), 128'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 128'(bus.s_ready), 128'(1));
    chk("rst_wuser",   128'(bus.AXIM_wuser), 128'(0));

    // Packet table
    for (int i = 0; i < NV; i++) begin
      send_pkt(vecs[i], i);
      collect_w(vecs[i], i, -1, 0);
    end

    // wready pattern 1,0,0,1 on the second beat
    send_pkt(vecs[0], 20);
    collect_w(vecs[0], 20, 1, 2);

    // Reset while replaying the second beat of a three-beat burst
    send_pkt(vecs[2], 30);
    bus.AXIM_wready = 1'b1;
    chk_beat(vecs[2], 30, 0);
    @(negedge clk);
    bus.AXIM_wready = 1'b0;
    chk_beat(vecs[2], 30, 1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_wvalid", 128'(bus.AXIM_wvalid), 128'(0));
    chk("mid_rst_wdata",  bus.AXIM_wdata, 128'(0));
    chk("mid_rst_wid",    128'(bus.AXIM_wid), 128'(0));
    chk("mid_rst_s_ready", 128'(bus.s_ready), 128'(1));
    @(negedge clk);
    resetn = 1'b1;
    send_pkt(vecs[7], 31);
    collect_w(vecs[7], 31, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
